// File: rtl/clint_pkg.sv
// clint_pkg: CLINT register offsets, bus response codes, FSM states and address decode helpers.
package clint_pkg;
  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI} sel_t;
  typedef struct packed {
    sel_t       sel;
    logic [2:0] resp;
  } dec_t;
  // Base mismatch wins over misalignment; only OKAY accesses select a register.
  function automatic dec_t decode(input logic [31:0] addr, input logic [15:0] base_hi);
    dec_t d;
    sel_t s;
    s = addr[15:0] == OFF_MSIP    ? SEL_MSIP    :
        addr[15:0] == OFF_CMP_LO  ? SEL_CMP_LO  :
        addr[15:0] == OFF_CMP_HI  ? SEL_CMP_HI  :
        addr[15:0] == OFF_TIME_LO ? SEL_TIME_LO :
        addr[15:0] == OFF_TIME_HI ? SEL_TIME_HI : SEL_NONE;
    d.resp = addr[31:16] != base_hi ? RESP_DECERR :
             addr[1:0] != 2'b00     ? RESP_SLVERR :
             s == SEL_NONE          ? RESP_DECERR : RESP_OKAY;
    d.sel  = d.resp == RESP_OKAY ? s : SEL_NONE;
    return d;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: mtime tick source; divides by PRESCALE when CLINT_PRESCALE_EN is defined, else ticks every cycle.
module clint_tick_gen #(
  parameter int PRESCALE = 10
) (
`ifdef CLINT_PRESCALE_EN
  input  logic clk,
  input  logic rst_n,
`endif
  output logic tick
);
  if (PRESCALE < 1) begin : g_chk
    $error("clint_tick_gen: PRESCALE must be at least 1");
  end
`ifdef CLINT_PRESCALE_EN
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt == LAST ? '0 : cnt + 1'b1;
  assign tick = cnt == LAST;
`else
  assign tick = 1'b1;
`endif
endmodule

// File: rtl/clint_slave.sv
// clint_slave: core-local interruptor (msip, mtimecmp, mtime) on the LSU SRAM-style bus.
// Define CLINT_PRESCALE_EN to advance mtime once every PRESCALE cycles.
module clint_slave
  import clint_pkg::*;
#(
  parameter int          DATA_LEN     = 32,
  parameter int          DATA_BIT_NUM = DATA_LEN / 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          PRESCALE     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_LEN-1:0]     waddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_LEN-1:0]     wdata,
  input  logic [DATA_BIT_NUM-1:0] wstrob,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [2:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [DATA_LEN-1:0]     raddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_LEN-1:0]     rdata,
  output logic [2:0]              rresp,
  output logic                    timer_irq,
  output logic                    soft_irq
);
  r_state_t                r_state;
  w_state_t                w_state;
  logic                    aw_got, w_got, tick, commit;
  logic [DATA_LEN-1:0]     addr_q, data_q, w_addr, w_data, rd_val;
  logic [DATA_BIT_NUM-1:0] strb_q, w_strb;
  logic [63:0]             mtime, mtimecmp;
  logic                    msip;
  dec_t                    wdec, rdec;
  sel_t                    wr_sel;

  clint_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
`ifdef CLINT_PRESCALE_EN
    .clk  (clk),
    .rst_n(rst_n),
`endif
    .tick (tick)
  );

  assign awready = !aw_got;
  assign wready  = !w_got;
  assign bvalid  = w_state == W_RESP;
  assign arready = r_state == R_IDLE;
  assign rvalid  = r_state == R_RESP;
  // A channel captured in an earlier cycle supplies its latched value; otherwise the live bus is used.
  assign w_addr  = aw_got ? addr_q : waddr;
  assign w_data  = w_got ? data_q : wdata;
  assign w_strb  = w_got ? strb_q : wstrob;
  assign commit  = w_state == W_IDLE && (aw_got || awvalid) && (w_got || wvalid);
  assign wdec    = decode(w_addr, BASE_ADDR[31:16]);
  assign rdec    = decode(raddr, BASE_ADDR[31:16]);
  assign wr_sel  = commit ? wdec.sel : SEL_NONE;

  always_comb begin
    rd_val = rdec.sel == SEL_MSIP    ? {{(DATA_LEN-1){1'b0}}, msip} :
             rdec.sel == SEL_CMP_LO  ? mtimecmp[31:0]  :
             rdec.sel == SEL_CMP_HI  ? mtimecmp[63:32] :
             rdec.sel == SEL_TIME_LO ? mtime[31:0]     :
             rdec.sel == SEL_TIME_HI ? mtime[63:32]    : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (arvalid) begin
        r_state <= R_RESP;
        rdata   <= rd_val;
        rresp   <= rdec.resp;
      end
    end else if (rready) r_state <= R_IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp   <= RESP_OKAY;
    end else if (w_state == W_RESP) begin
      if (bready) begin
        w_state <= W_IDLE;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
      end
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1;
        addr_q <= waddr;
      end
      if (wvalid && wready) begin
        w_got  <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrob;
      end
      if (commit) begin
        w_state <= W_RESP;
        bresp   <= wdec.resp;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      if (wr_sel == SEL_MSIP && w_strb[0]) msip <= w_data[0];
      if (wr_sel == SEL_CMP_LO) mtimecmp[31:0] <= merge(mtimecmp[31:0], w_data, w_strb);
      if (wr_sel == SEL_CMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], w_data, w_strb);
      // A write to either mtime half replaces that cycle's increment.
      if (wr_sel == SEL_TIME_LO) mtime <= {mtime[63:32], merge(mtime[31:0], w_data, w_strb)};
      else if (wr_sel == SEL_TIME_HI) mtime <= {merge(mtime[63:32], w_data, w_strb), mtime[31:0]};
      else if (tick) mtime <= mtime + 64'd1;
      timer_irq <= mtime >= mtimecmp;
      soft_irq  <= msip;
    end
endmodule

// File: tb/tb_clint_slave.sv
// tb_clint_slave: directed checks of the CLINT slave (default build: mtime ticks every cycle).
module tb_clint_slave;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wstrob = '0;
  logic        awready, wready, bvalid, arready, rvalid, timer_irq, soft_irq;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;
  int          n_chk = 0, n_fail = 0;

  clint_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .waddr(waddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrob(wstrob),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .raddr(raddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic [2:0] exp_r, input int hold);
    int n;
    logic [31:0] d;
    n = 0;
    arvalid = 1'b1;
    raddr   = a;
    @(negedge clk);
    while (!rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, rvalid, 1);
    arvalid = 1'b0;
    d = rdata;
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_rresp"}, rresp, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_rvalid"}, rvalid, 1);
      chk({tag, "_hold_rdata"}, rdata, d);
      chk({tag, "_hold_arready"}, arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [2:0] exp_r);
    int n;
    n = 0;
    awvalid = 1'b1; waddr = a;
    wvalid  = 1'b1; wdata = d; wstrob = s;
    @(negedge clk);
    while (!bvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp_r);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_timer_irq", timer_irq, 0);
    chk("rst_soft_irq", soft_irq, 0);
    // mtime read right after reset release: latched before the first increment
    rst_n = 1'b1;
    rd("mtime_lo0", 32'h0200_BFF8, 32'h0, 3'b000, 0);
    rd("mtime_hi0", 32'h0200_BFFC, 32'h0, 3'b000, 0);
    chk("timer_irq_init", timer_irq, 0);
    // mtimecmp = 0x10, mtime = 0 -> timer_irq rises 17 cycles after the mtime write commits
    wr("cmp_hi", 32'h0200_4004, 32'h0, 4'hF, 3'b000);
    wr("cmp_lo", 32'h0200_4000, 32'h10, 4'hF, 3'b000);
    wr("mtime_lo", 32'h0200_BFF8, 32'h0, 4'hF, 3'b000);
    chk("timer_irq_early", timer_irq, 0);
    repeat (15) @(negedge clk);
    chk("timer_irq_before", timer_irq, 0);
    @(negedge clk);
    chk("timer_irq_rise", timer_irq, 1);
    // W channel two cycles ahead of AW, msip set
    wvalid = 1'b1; wdata = 32'hFF; wstrob = 4'b0001;
    @(negedge clk);
    chk("w_first_wready", wready, 0);
    chk("w_first_awready", awready, 1);
    chk("w_first_bvalid", bvalid, 0);
    wvalid = 1'b0;
    @(negedge clk);
    chk("w_wait_bvalid", bvalid, 0);
    awvalid = 1'b1; waddr = 32'h0200_0000;
    @(negedge clk);
    chk("aw_late_bvalid", bvalid, 1);
    chk("aw_late_bresp", bresp, 0);
    chk("soft_irq_lag", soft_irq, 0);
    awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("soft_irq_set", soft_irq, 1);
    rd("msip_rb", 32'h0200_0000, 32'h1, 3'b000, 0);
    // Error responses
    rd("unmapped", 32'h0200_1000, 32'h0, 3'b011, 0);
    rd("misaligned", 32'h0200_4002, 32'h0, 3'b010, 0);
    rd("base_mismatch", 32'h0300_0000, 32'h0, 3'b011, 0);
    wr("wr_unmapped", 32'h0200_8000, 32'hFFFF_FFFF, 4'hF, 3'b011);
    rd("msip_keep", 32'h0200_0000, 32'h1, 3'b000, 0);
    rd("cmp_lo_keep", 32'h0200_4000, 32'h10, 3'b000, 0);
    // Partial strobe keeps unwritten bytes
    wr("cmp_hi_byte2", 32'h0200_4004, 32'hAACD_BBCC, 4'b0100, 3'b000);
    rd("cmp_hi_merge", 32'h0200_4004, 32'h00CD_0000, 3'b000, 0);
    // Read in the same cycle as a write commit sees the old value
    awvalid = 1'b1; waddr = 32'h0200_0000; wvalid = 1'b1; wdata = 32'h0; wstrob = 4'b0001;
    arvalid = 1'b1; raddr = 32'h0200_0000;
    @(negedge clk);
    chk("same_bvalid", bvalid, 1);
    chk("same_rvalid", rvalid, 1);
    chk("same_rdata_old", rdata, 1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    rd("msip_cleared", 32'h0200_0000, 32'h0, 3'b000, 0);
    // mtime wrap, then a stalled read response
    wr("mtime_hi_ones", 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 3'b000);
    wr("mtime_lo_ones", 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 3'b000);
    rd("wrap_lo", 32'h0200_BFF8, 32'h0, 3'b000, 0);
    rd("wrap_hi", 32'h0200_BFFC, 32'h0, 3'b000, 5);
    // Reset while a write response is pending
    awvalid = 1'b1; waddr = 32'h0200_0000; wvalid = 1'b1; wdata = 32'h1; wstrob = 4'b0001;
    @(negedge clk);
    chk("pend_bvalid", bvalid, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bvalid", bvalid, 0);
    chk("arst_awready", awready, 1);
    chk("arst_wready", wready, 1);
    chk("arst_soft_irq", soft_irq, 0);
    chk("arst_timer_irq", timer_irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("post_rst_msip", 32'h0200_0000, 32'h0, 3'b000, 0);
    rd("post_rst_cmp_hi", 32'h0200_4004, 32'hFFFF_FFFF, 3'b000, 0);
    rd("post_rst_mtime_hi", 32'h0200_BFFC, 32'h0, 3'b000, 0);
    chk("post_rst_soft_irq", soft_irq, 0);
    chk("post_rst_timer_irq", timer_irq, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clint_slave.md
# clint_slave

Memory-mapped core-local interruptor acting as a responder on the core's SRAM-style load/store bus: accepts write address/data and read address handshakes from the LSU, answers with write and read responses. Holds the machine timer (`mtime`), timer compare (`mtimecmp`) and software-interrupt bit (`msip`), and drives `timer_irq`/`soft_irq` toward the CSR block. Sits beside `lsu_sram` behind the LSU address decoder.

## Interface
- `DATA_LEN`, 32: bus data/address width.
- `DATA_BIT_NUM`, `DATA_LEN/8`: write-strobe width.
- `BASE_ADDR`, 32'h0200_0000: block base; upper 16 address bits must match `BASE_ADDR[31:16]`.
- `PRESCALE`, 10: `mtime` tick divisor (used only with `CLINT_PRESCALE_EN`).

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `awvalid` in 1 / `awready` out 1 / `waddr` in DATA_LEN: write address channel.
- `wvalid` in 1 / `wready` out 1 / `wdata` in DATA_LEN / `wstrob` in DATA_BIT_NUM: write data channel.
- `bvalid` out 1 / `bready` in 1 / `bresp` out 3: write response.
- `arvalid` in 1 / `arready` out 1 / `raddr` in DATA_LEN: read address.
- `rvalid` out 1 / `rready` in 1 / `rdata` out DATA_LEN / `rresp` out 3: read response.
- `timer_irq` out 1: `mtime >= mtimecmp`, registered.
- `soft_irq` out 1: `msip[0]`, registered.

## Operation
- Register map (offset from base): 0x0000 `msip` (bit0 RW, others read 0); 0x4000/0x4004 `mtimecmp` lo/hi; 0xBFF8/0xBFFC `mtime` lo/hi.
- Responses: 3'b000 OKAY; 3'b010 SLVERR for `addr[1:0]!=0`; 3'b011 DECERR for unmapped offset or upper-bit mismatch. Error reads return `rdata=0`; error writes change nothing.
- Read FSM R_IDLE/R_RESP: R_IDLE `arready=1`; on `arvalid&arready` latch `rdata`/`rresp` from current register values, go R_RESP. R_RESP `rvalid=1`, data stable; on `rready` return to R_IDLE.
- Write FSM W_IDLE/W_RESP: address and data captured independently, any order or same cycle; `awready` drops after AW handshake, `wready` after W handshake, until the response completes. At the edge where the second handshake completes, commit bytes per `wstrob`, go W_RESP. W_RESP `bvalid=1`; on `bready` return to W_IDLE, both readies high again.
- `mtime` 64-bit, increments by 1 per tick, wraps all-ones -> 0. Tick cycle with a committed write to either `mtime` half: no increment; written bytes take new data, unwritten bytes keep old value.
- Read and write FSMs independent; a read in the same cycle as a write commit returns pre-write values.
- Reset (any time, incl. mid-transaction): both FSMs idle, pending captures dropped, `mtime=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`.

## Timing
- Reset values: `arready=1`, `awready=1`, `wready=1`, `rvalid=0`, `bvalid=0`, `rdata=0`, `rresp=0`, `bresp=0`, `timer_irq=0`, `soft_irq=0`.
- Read latency: `rvalid` rises the cycle after AR handshake; back-to-back reads every 2 cycles with `rready` held high.
- Write latency: `bvalid` rises the cycle after the later of AW/W handshakes; register value visible to reads from that same cycle.
- `timer_irq`/`soft_irq` lag the register state by exactly one cycle.

## Configuration
- `CLINT_PRESCALE_EN` defined: tick once every `PRESCALE` cycles via a modulo counter (reset 0, wraps at `PRESCALE-1`; counter not reset by `mtime` writes).
- Not defined: tick every cycle; `PRESCALE` ignored, no counter instantiated.

## Structure
- `clint_pkg`: register offsets, response codes (OKAY/SLVERR/DECERR), read/write FSM state typedefs.
- One sub-module `clint_tick_gen`: prescaler producing the 1-cycle `tick` pulse (constant 1 when macro off).

## Test plan
- Reset, read 0xBFF8 then 0xBFFC immediately -> OKAY, lo small count, hi 0; `timer_irq=0`.
- Write `mtimecmp`=0x0000_0000_0000_0010 (hi then lo), `mtime`=0 -> `timer_irq` rises one cycle after `mtime` reaches 0x10 (x`PRESCALE` cycles with macro).
- W data two cycles before AW, `wstrob=4'b0001`, `wdata=0xFF` to 0x0000 -> `bvalid` next cycle after AW, `soft_irq=1` one cycle later; readback 0x1.
- Read 0x1000 -> `rresp=3'b011`, `rdata=0`; read 0x4002 -> `rresp=3'b010`; write to 0x8000 -> `bresp=3'b011`, registers unchanged.
- `mtime`=0xFFFF_FFFF_FFFF_FFFF -> next tick reads 0; `rready` held low 5 cycles -> `rvalid`/`rdata` stable, `arready=0` throughout.
- Assert `rst_n` low while `bvalid` pending -> `bvalid=0` and readies high immediately, `msip=0`.
